// File: rtl/program_loader.sv
// Boot-stage loader: streams a program image into instruction/data memories, reads the
// instruction image back for an XOR checksum, then enables the CPU until stopped.
module program_loader #(
    parameter int unsigned IMEM_DEPTH = 512,
    parameter int unsigned DMEM_DEPTH = 1024,
    parameter int unsigned CNT_W      = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        s_valid,
    input  logic [63:0] s_data,
    output logic        s_ready,
    output logic [63:0] addr_ext,
    output logic        wen_ext,
    output logic        ren_ext,
    output logic [31:0] wdata_ext,
    input  logic [31:0] rdata_ext,
    output logic [63:0] addr_ext_2,
    output logic        wen_ext_2,
    output logic        ren_ext_2,
    output logic [63:0] wdata_ext_2,
    output logic        cpu_enable,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        StIdle, StHeader, StLoadI, StLoadD, StVerify, StCheck, StRun, StError
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] n_i_q, n_i_d, n_d_q, n_d_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      csum_w_q, csum_w_d, csum_r_q, csum_r_d;
    logic             rd_vld_q;
    logic             xfer;
    logic [CNT_W-1:0] hdr_n_i, hdr_n_d;
    logic [63:0]      cnt_ext;

    assign xfer      = s_valid & s_ready;
    assign hdr_n_i   = s_data[CNT_W-1:0];
    assign hdr_n_d   = s_data[32+CNT_W-1:32];
    assign cnt_ext   = 64'(cnt_q);
    assign ren_ext_2 = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            n_i_q    <= '0;
            n_d_q    <= '0;
            cnt_q    <= '0;
            csum_w_q <= '0;
            csum_r_q <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_i_q    <= n_i_d;
            n_d_q    <= n_d_d;
            cnt_q    <= cnt_d;
            csum_w_q <= csum_w_d;
            csum_r_q <= csum_r_d;
            // Read data returns one cycle after the strobe.
            rd_vld_q <= ren_ext;
        end
    end

    always_comb begin
        state_d     = state_q;
        n_i_d       = n_i_q;
        n_d_d       = n_d_q;
        cnt_d       = cnt_q;
        csum_w_d    = csum_w_q;
        csum_r_d    = rd_vld_q ? (csum_r_q ^ rdata_ext) : csum_r_q;
        s_ready     = 1'b0;
        addr_ext    = '0;
        wen_ext     = 1'b0;
        ren_ext     = 1'b0;
        wdata_ext   = '0;
        addr_ext_2  = '0;
        wen_ext_2   = 1'b0;
        wdata_ext_2 = '0;
        cpu_enable  = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        error       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StHeader;
                    cnt_d    = '0;
                    csum_w_d = '0;
                    csum_r_d = '0;
                end
            end
            StHeader: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (xfer) begin
                    n_i_d = hdr_n_i;
                    n_d_d = hdr_n_d;
                    cnt_d = '0;
                    if (32'(hdr_n_i) > IMEM_DEPTH || 32'(hdr_n_d) > DMEM_DEPTH) begin
                        state_d = StError;
                    end else if (hdr_n_i != '0) begin
                        state_d = StLoadI;
                    end else if (hdr_n_d != '0) begin
                        state_d = StLoadD;
                    end else begin
                        state_d = StVerify;
                    end
                end
            end
            StLoadI: begin
                s_ready   = 1'b1;
                busy      = 1'b1;
                wen_ext   = s_valid;
                addr_ext  = cnt_ext << 2;
                wdata_ext = s_valid ? s_data[31:0] : '0;
                if (xfer) begin
                    csum_w_d = csum_w_q ^ s_data[31:0];
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == n_i_q - 1'b1) begin
                        cnt_d   = '0;
                        state_d = (n_d_q != '0) ? StLoadD : StVerify;
                    end
                end
            end
            StLoadD: begin
                s_ready     = 1'b1;
                busy        = 1'b1;
                wen_ext_2   = s_valid;
                addr_ext_2  = cnt_ext << 3;
                wdata_ext_2 = s_valid ? s_data : '0;
                if (xfer) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == n_d_q - 1'b1) begin
                        cnt_d   = '0;
                        state_d = StVerify;
                    end
                end
            end
            StVerify: begin
                busy = 1'b1;
                // Once every read is issued, the remaining cycle drains the last return.
                if (cnt_q != n_i_q) begin
                    ren_ext  = 1'b1;
                    addr_ext = cnt_ext << 2;
                    cnt_d    = cnt_q + 1'b1;
                end else begin
                    state_d = StCheck;
                end
            end
            StCheck: begin
                busy = 1'b1;
                if (csum_w_q == csum_r_q) begin
                    done    = 1'b1;
                    state_d = StRun;
                end else begin
                    state_d = StError;
                end
            end
            StRun: begin
                cpu_enable = 1'b1;
                if (stop) begin
                    state_d = StIdle;
                end
            end
            StError: begin
                error = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: memory models, expected-transaction queues and a
// per-cycle compare process, plus literal checks on the nominal image.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst, start, stop, s_valid;
    logic [63:0] s_data;
    logic        s_ready;
    logic [63:0] addr_ext, addr_ext_2, wdata_ext_2;
    logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2;
    logic [31:0] wdata_ext, rdata_ext;
    logic        cpu_enable, busy, done, error;

    always #5 clk = ~clk;

    program_loader #(
        .IMEM_DEPTH(512),
        .DMEM_DEPTH(1024),
        .CNT_W     (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .addr_ext   (addr_ext),
        .wen_ext    (wen_ext),
        .ren_ext    (ren_ext),
        .wdata_ext  (wdata_ext),
        .rdata_ext  (rdata_ext),
        .addr_ext_2 (addr_ext_2),
        .wen_ext_2  (wen_ext_2),
        .ren_ext_2  (ren_ext_2),
        .wdata_ext_2(wdata_ext_2),
        .cpu_enable (cpu_enable),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_wr_i = 0, n_wr_d = 0, n_rd = 0, n_done = 0;
    bit prev_done = 0;

    logic [31:0] img_i [3];
    logic [63:0] img_d [2];

    logic [63:0] q_ia[$], q_id[$], q_da[$], q_dd[$], q_ra[$];

    logic [31:0] imem [512];
    logic [63:0] dmem [1024];
    bit          clr_mem = 0;
    bit          corrupt_en = 0;
    logic [8:0]  corrupt_idx = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_evt(input string name, input logic [63:0] info);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got event 0x%0h, expected none", name, info);
    endtask

    // Memory models; read data returns one cycle after ren_ext, optionally corrupted.
    always @(posedge clk) begin
        if (clr_mem) begin
            for (int a = 0; a < 512; a++) imem[a] <= '0;
            for (int a = 0; a < 1024; a++) dmem[a] <= '0;
        end
        if (wen_ext) imem[addr_ext[10:2]] <= wdata_ext;
        if (wen_ext_2) dmem[addr_ext_2[12:3]] <= wdata_ext_2;
        if (ren_ext)
            rdata_ext <= imem[addr_ext[10:2]] ^
                         ((corrupt_en && addr_ext[10:2] == corrupt_idx) ? 32'h1 : 32'h0);
    end

    // Compare process: every strobe must match the next expected transaction.
    always @(negedge clk) begin
        if (!rst) begin
            if (wen_ext) begin
                n_wr_i++;
                check("imem_wr_needs_valid", 64'(s_valid), 64'd1);
                if (q_ia.size() == 0) fail_evt("imem_wr_unexpected", addr_ext);
                else begin
                    check("imem_wr_addr", addr_ext, q_ia.pop_front());
                    check("imem_wr_data", 64'(wdata_ext), q_id.pop_front());
                end
            end
            if (wen_ext_2) begin
                n_wr_d++;
                check("dmem_wr_needs_valid", 64'(s_valid), 64'd1);
                if (q_da.size() == 0) fail_evt("dmem_wr_unexpected", addr_ext_2);
                else begin
                    check("dmem_wr_addr", addr_ext_2, q_da.pop_front());
                    check("dmem_wr_data", wdata_ext_2, q_dd.pop_front());
                end
            end
            if (ren_ext) begin
                n_rd++;
                if (q_ra.size() == 0) fail_evt("imem_rd_unexpected", addr_ext);
                else check("imem_rd_addr", addr_ext, q_ra.pop_front());
            end
            check("strobe_exclusive", 64'(int'(wen_ext) + int'(ren_ext) + int'(wen_ext_2) <= 1),
                  64'd1);
            check("ren_ext_2_zero", 64'(ren_ext_2), 64'd0);
            if (done) n_done++;
            if (prev_done) check("cpu_en_after_done", 64'(cpu_enable), 64'd1);
            if (error) check("error_quiet", 64'({cpu_enable, s_ready, busy}), 64'd0);
        end
        prev_done = done & ~rst;
    end

    function automatic logic [63:0] hdr(input int ni, input int nd);
        return {32'(nd), 32'(ni)};
    endfunction

    task automatic expect_image(input int ni, input int nd, input int nreads);
        for (int k = 0; k < ni; k++) begin
            q_ia.push_back(64'(4 * k));
            q_id.push_back(64'(img_i[k]));
        end
        for (int k = 0; k < nd; k++) begin
            q_da.push_back(64'(8 * k));
            q_dd.push_back(img_d[k]);
        end
        for (int k = 0; k < nreads; k++) q_ra.push_back(64'(4 * k));
    endtask

    task automatic clear_counts();
        n_wr_i = 0; n_wr_d = 0; n_rd = 0; n_done = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] w, input bit bubble);
        int t;
        t = 0;
        if (bubble) begin
            s_valid = 1'b0;
            s_data  = '0;
            tick();
        end
        s_valid = 1'b1;
        s_data  = w;
        while (!s_ready && t < 20) begin
            tick();
            t++;
        end
        if (!s_ready) fail_evt("s_ready_timeout", w);
        tick();
        s_valid = 1'b0;
        s_data  = '0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    // Sends header and full image; returns the cycle stamp just after the header transfer.
    task automatic load(input int ni, input int nd, input bit bubble, output int hc);
        pulse_start();
        send(hdr(ni, nd), 1'b0);
        hc = cyc;
        for (int k = 0; k < ni; k++) send(64'(img_i[k]), bubble);
        for (int k = 0; k < nd; k++) send(img_d[k], bubble);
    endtask

    task automatic wait_end(input int maxc, output bit got_done, output int at_cyc);
        bit fin;
        int t;
        fin = 0; t = 0; got_done = 0; at_cyc = -1;
        while (!fin && t < maxc) begin
            @(negedge clk);
            t++;
            if (done) begin got_done = 1; at_cyc = cyc; fin = 1; end
            else if (error) begin at_cyc = cyc; fin = 1; end
        end
        if (!fin) fail_evt("wait_timeout", 64'(maxc));
    endtask

    task automatic check_queues(input string name);
        check(name, 64'(q_ia.size() + q_da.size() + q_ra.size()), 64'd0);
        q_ia.delete(); q_id.delete(); q_da.delete(); q_dd.delete(); q_ra.delete();
    endtask

    initial begin
        bit got;
        int hc, dc;
        rst = 1'b1; start = 1'b0; stop = 1'b0; s_valid = 1'b0; s_data = '0;
        img_i[0] = 32'h00500093; img_i[1] = 32'h00A00113; img_i[2] = 32'h002081B3;
        img_d[0] = 64'h11;       img_d[1] = 64'h22;
        clr_mem = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clr_mem = 1'b0;

        // Reset state
        check("rst_outputs", 64'({s_ready, wen_ext, ren_ext, wen_ext_2, cpu_enable, busy,
                                  done, error}), 64'd0);

        // 1. Nominal load
        clear_counts();
        expect_image(3, 2, 3);
        pulse_start();
        check("t1_header_ready", 64'({s_ready, busy}), 64'b11);
        send(hdr(3, 2), 1'b0);
        hc = cyc;
        for (int k = 0; k < 3; k++) send(64'(img_i[k]), 1'b0);
        for (int k = 0; k < 2; k++) send(img_d[k], 1'b0);
        wait_end(100, got, dc);
        check("t1_done", 64'(got), 64'd1);
        check("t1_latency", 64'(dc - hc), 64'(2 * 3 + 2 + 1));
        tick();
        check("t1_cpu_enable", 64'(cpu_enable), 64'd1);
        check("t1_not_busy", 64'({busy, done}), 64'd0);
        check("t1_imem0", 64'(imem[0]), 64'h00500093);
        check("t1_imem1", 64'(imem[1]), 64'h00A00113);
        check("t1_imem2", 64'(imem[2]), 64'h002081B3);
        check("t1_dmem0", dmem[0], 64'h11);
        check("t1_dmem1", dmem[1], 64'h22);
        check("t1_writes", 64'(n_wr_i + n_wr_d), 64'd5);
        check("t1_reads", 64'(n_rd), 64'd3);
        check("t1_done_count", 64'(n_done), 64'd1);
        check_queues("t1_queues_drained");
        pulse_stop();
        check("t1_stop", 64'(cpu_enable), 64'd0);

        // 2. Stream bubbles
        clr_mem = 1'b1;
        tick();
        clr_mem = 1'b0;
        clear_counts();
        expect_image(3, 2, 3);
        load(3, 2, 1'b1, hc);
        wait_end(100, got, dc);
        check("t2_done", 64'(got), 64'd1);
        tick();
        for (int k = 0; k < 3; k++) check("t2_imem", 64'(imem[k]), 64'(img_i[k]));
        for (int k = 0; k < 2; k++) check("t2_dmem", dmem[k], img_d[k]);
        check("t2_writes", 64'(n_wr_i + n_wr_d), 64'd5);
        check_queues("t2_queues_drained");
        pulse_stop();

        // 3. Oversize header
        clear_counts();
        pulse_start();
        send(hdr(513, 0), 1'b0);
        check("t3_error", 64'({error, busy, s_ready}), 64'b100);
        repeat (3) tick();
        pulse_start();
        check("t3_error_sticky", 64'(error), 64'd1);
        check("t3_no_strobes", 64'(n_wr_i + n_wr_d + n_rd), 64'd0);
        pulse_rst();
        check("t3_cleared", 64'({error, busy, s_ready, cpu_enable}), 64'd0);
        pulse_start();
        check("t3_idle_then_header", 64'(s_ready), 64'd1);
        pulse_rst();

        // 4. Checksum failure: read k=1 corrupted
        clear_counts();
        corrupt_en  = 1'b1;
        corrupt_idx = 9'd1;
        expect_image(3, 2, 3);
        load(3, 2, 1'b0, hc);
        wait_end(100, got, dc);
        check("t4_no_done", 64'(got), 64'd0);
        check("t4_error", 64'(error), 64'd1);
        tick();
        check("t4_cpu_enable", 64'(cpu_enable), 64'd0);
        check("t4_done_count", 64'(n_done), 64'd0);
        check_queues("t4_queues_drained");
        corrupt_en = 1'b0;
        pulse_rst();

        // 5. Empty image
        clear_counts();
        load(0, 0, 1'b0, hc);
        wait_end(20, got, dc);
        check("t5_done", 64'(got), 64'd1);
        check("t5_latency", 64'(dc - hc), 64'd1);
        tick();
        check("t5_run", 64'(cpu_enable), 64'd1);
        check("t5_no_strobes", 64'(n_wr_i + n_wr_d + n_rd), 64'd0);
        pulse_stop();

        // 6. Reset mid-load, then fresh load, start ignored in RUN, stop
        clear_counts();
        expect_image(2, 0, 0);
        pulse_start();
        send(hdr(3, 2), 1'b0);
        send(64'(img_i[0]), 1'b0);
        send(64'(img_i[1]), 1'b0);
        pulse_rst();
        check("t6_rst_flags", 64'({s_ready, wen_ext, ren_ext, wen_ext_2, ren_ext_2, cpu_enable,
                                   busy, done, error}), 64'd0);
        check("t6_rst_addr", addr_ext | addr_ext_2, 64'd0);
        check("t6_rst_wdata", 64'(wdata_ext) | wdata_ext_2, 64'd0);
        check("t6_partial_writes", 64'(n_wr_i), 64'd2);
        check_queues("t6_partial_drained");
        clear_counts();
        expect_image(3, 2, 3);
        load(3, 2, 1'b0, hc);
        wait_end(100, got, dc);
        check("t6_done", 64'(got), 64'd1);
        check("t6_latency", 64'(dc - hc), 64'(2 * 3 + 2 + 1));
        tick();
        pulse_start();
        check("t6_start_ignored", 64'({cpu_enable, busy, s_ready}), 64'b100);
        pulse_stop();
        check("t6_stop", 64'({cpu_enable, busy}), 64'd0);
        check_queues("t6_queues_drained");

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
